ssd_scan_ctl: RTL and testbench

Downstream consumer of the BCD counter chain. Takes four BCD digits (ones through thousands, i.e. up-counter `value` outputs) plus per-digit decimal points. Time-multiplexes them onto a 4-digit common-anode seven-segment display. Latches all digits once per scan frame so a counter carry never tears across digits mid-frame.

---
 rtl/ssd_scan_ctl_pkg.sv | 32 +++
 rtl/ssd_scan_ctl_if.sv | 24 ++
 rtl/ssd_scan_ctl_bcd_to_ssd.sv | 32 +++
 rtl/ssd_scan_ctl.sv | 101 ++++++++++
 tb/tb_ssd_scan_ctl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/ssd_scan_ctl_pkg.sv
// Shared constants for the seven-segment scan controller: BCD widths, enable levels
// and active-low segment glyphs {a,b,c,d,e,f,g,dp}.
package ssd_scan_ctl_pkg;

  localparam int BCD_BIT_WIDTH = 4;
  localparam int SSD_DIGIT_NUM = 4;

  localparam logic [BCD_BIT_WIDTH-1:0] BCD_ZERO = 4'd0;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_NINE = 4'd9;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  localparam logic [7:0] SSD_ZERO  = 8'h03;
  localparam logic [7:0] SSD_ONE   = 8'h9F;
  localparam logic [7:0] SSD_TWO   = 8'h25;
  localparam logic [7:0] SSD_THREE = 8'h0D;
  localparam logic [7:0] SSD_FOUR  = 8'h99;
  localparam logic [7:0] SSD_FIVE  = 8'h49;
  localparam logic [7:0] SSD_SIX   = 8'h41;
  localparam logic [7:0] SSD_SEVEN = 8'h1F;
  localparam logic [7:0] SSD_EIGHT = 8'h01;
  localparam logic [7:0] SSD_NINE  = 8'h09;
  localparam logic [7:0] SSD_DASH  = 8'hFD;
  localparam logic [7:0] SSD_BLANK = 8'hFF;

  // Active-low digit enable selecting a single digit.
  function automatic logic [SSD_DIGIT_NUM-1:0] digit_sel_n(input logic [1:0] idx);
    return ~(SSD_DIGIT_NUM'(1) << idx);
  endfunction

endpackage

// File: rtl/ssd_scan_ctl_if.sv
// Digit/segment bus between the BCD counter chain and the display scanner.
interface ssd_scan_ctl_if;
  import ssd_scan_ctl_pkg::*;

  logic [BCD_BIT_WIDTH-1:0] bcd0;
  logic [BCD_BIT_WIDTH-1:0] bcd1;
  logic [BCD_BIT_WIDTH-1:0] bcd2;
  logic [BCD_BIT_WIDTH-1:0] bcd3;
  logic [3:0]               dp_in;
  logic                     disp_en;
  logic [3:0]               ssd_ctl;
  logic [7:0]               segs;
  logic                     frame_start;

  modport master (
    output bcd0, bcd1, bcd2, bcd3, dp_in, disp_en,
    input  ssd_ctl, segs, frame_start
  );

  modport slave (
    input  bcd0, bcd1, bcd2, bcd3, dp_in, disp_en,
    output ssd_ctl, segs, frame_start
  );
endinterface

// File: rtl/ssd_scan_ctl_bcd_to_ssd.sv
// Combinational BCD-to-seven-segment decoder (active-low); codes above nine show a dash.
module bcd_to_ssd
  import ssd_scan_ctl_pkg::*;
(
  input  logic [BCD_BIT_WIDTH-1:0] bcd_i,
  input  logic                     dp_i,
  output logic [7:0]               segs_o
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SSD_DASH;
    if (bcd_i <= BCD_NINE) begin
      case (bcd_i)
        4'd0:    glyph = SSD_ZERO;
        4'd1:    glyph = SSD_ONE;
        4'd2:    glyph = SSD_TWO;
        4'd3:    glyph = SSD_THREE;
        4'd4:    glyph = SSD_FOUR;
        4'd5:    glyph = SSD_FIVE;
        4'd6:    glyph = SSD_SIX;
        4'd7:    glyph = SSD_SEVEN;
        4'd8:    glyph = SSD_EIGHT;
        default: glyph = SSD_NINE;
      endcase
    end
  end

  assign segs_o = {glyph[7:1], glyph[0] & ~dp_i};

endmodule

// File: rtl/ssd_scan_ctl.sv
// Four-digit common-anode display scanner with once-per-frame digit latch.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module ssd_scan_ctl
  import ssd_scan_ctl_pkg::*;
#(
  parameter int SCAN_PERIOD = 50000,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  ssd_scan_ctl_if.slave   bus
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SCAN_PERIOD - 1);

  logic [CNT_W-1:0]                            pre_cnt_q, pre_cnt_d;
  logic [1:0]                                  scan_idx_q, scan_idx_d;
  logic [SSD_DIGIT_NUM-1:0][BCD_BIT_WIDTH-1:0] dig_q, dig_d;
  logic [SSD_DIGIT_NUM-1:0]                    dp_q, dp_d;
  logic                                        frame_start_q, frame_start_d;
  logic [SSD_DIGIT_NUM-1:0]                    ssd_ctl_q, ssd_ctl_d;
  logic [7:0]                                  segs_q, segs_d;

  logic                     tick;
  logic                     frame_latch;
  logic [BCD_BIT_WIDTH-1:0] cur_bcd;
  logic                     cur_dp;
  logic                     cur_blank;
  logic [7:0]               cur_glyph;

  assign tick        = (pre_cnt_q == PRE_LAST);
  assign frame_latch = tick && (scan_idx_q == 2'd3);
  assign cur_bcd     = dig_q[scan_idx_q];
  assign cur_dp      = dp_q[scan_idx_q];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks only when it and every digit to its left latched as zero.
  always_comb begin
    cur_blank = 1'b0;
    case (scan_idx_q)
      2'd3:    cur_blank = (dig_q[3] == BCD_ZERO);
      2'd2:    cur_blank = (dig_q[3] == BCD_ZERO) && (dig_q[2] == BCD_ZERO);
      2'd1:    cur_blank = (dig_q[3] == BCD_ZERO) && (dig_q[2] == BCD_ZERO)
                           && (dig_q[1] == BCD_ZERO);
      default: cur_blank = 1'b0;
    endcase
  end
`else
  assign cur_blank = 1'b0;
`endif

  bcd_to_ssd u_dec (
    .bcd_i  (cur_bcd),
    .dp_i   (cur_dp),
    .segs_o (cur_glyph)
  );

  always_comb begin
    pre_cnt_d     = tick ? '0 : pre_cnt_q + 1'b1;
    scan_idx_d    = tick ? scan_idx_q + 2'd1 : scan_idx_q;
    dig_d         = dig_q;
    dp_d          = dp_q;
    frame_start_d = frame_latch;
    if (frame_latch) begin
      dig_d = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
      dp_d  = bus.dp_in;
    end
    // Display stage lags scan_idx by one cycle; disable only masks this stage.
    ssd_ctl_d = digit_sel_n(scan_idx_q);
    segs_d    = cur_blank ? {SSD_BLANK[7:1], ~cur_dp} : cur_glyph;
    if (bus.disp_en == DISABLED) begin
      ssd_ctl_d = '1;
      segs_d    = SSD_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt_q     <= '0;
      scan_idx_q    <= '0;
      dig_q         <= '0;
      dp_q          <= '0;
      frame_start_q <= 1'b0;
      ssd_ctl_q     <= '1;
      segs_q        <= SSD_BLANK;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      scan_idx_q    <= scan_idx_d;
      dig_q         <= dig_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
      ssd_ctl_q     <= ssd_ctl_d;
      segs_q        <= segs_d;
    end
  end

  assign bus.ssd_ctl     = ssd_ctl_q;
  assign bus.segs        = segs_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Scoreboard bench for ssd_scan_ctl: a cycle-count display model predicts every output cycle.
module tb_ssd_scan_ctl;

  localparam int P     = 4;
  localparam int FRAME = 4 * P;

  typedef struct packed {
    logic [3:0] ctl;
    logic [7:0] segs;
    logic       fs;
  } exp_t;

  logic clk;
  logic rst;
  ssd_scan_ctl_if bus();

  ssd_scan_ctl #(.SCAN_PERIOD(P), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] GLYPH [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                             8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         n      = 0;
  logic [3:0] lat [4];
  logic [3:0] lat_dp;

  // Glyph the display should show for a digit position given the frame's latched values.
  function automatic logic [7:0] glyph_of(input int idx);
    logic [7:0] s;
    bit         blank;
    s     = (lat[idx] < 10) ? GLYPH[lat[idx]] : 8'hFD;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0) begin
      blank = 1'b1;
      for (int j = idx; j < 4; j++) if (lat[j] != 0) blank = 1'b0;
    end
`endif
    if (blank) s = 8'hFF;
    if (lat_dp[idx]) s[0] = 1'b0;
    return s;
  endfunction

  // Reference model: position in the scan follows from cycles elapsed since reset.
  always @(posedge clk) begin
    exp_t e;
    int   idx;
    if (!rst) begin
      n      = 0;
      for (int j = 0; j < 4; j++) lat[j] = 4'd0;
      lat_dp = 4'd0;
      e      = '{ctl: 4'hF, segs: 8'hFF, fs: 1'b0};
    end else begin
      idx    = (n / P) % 4;
      e.fs   = ((n % FRAME) == FRAME - 1);
      e.ctl  = bus.disp_en ? ~(4'b0001 << idx) : 4'hF;
      e.segs = bus.disp_en ? glyph_of(idx) : 8'hFF;
      if (e.fs) begin
        lat[0] = bus.bcd0;
        lat[1] = bus.bcd1;
        lat[2] = bus.bcd2;
        lat[3] = bus.bcd3;
        lat_dp = bus.dp_in;
      end
      n++;
    end
    q.push_back(e);
  end

  // Monitor: compare the registered outputs shortly after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t: got ctl=%b segs=%h fs=%b, required a queued expectation",
               $time, bus.ssd_ctl, bus.segs, bus.frame_start);
    end else begin
      e = q.pop_front();
      if (bus.ssd_ctl !== e.ctl || bus.segs !== e.segs || bus.frame_start !== e.fs) begin
        errors++;
        $display("FAIL display_out at %0t: got ctl=%b segs=%h fs=%b, required ctl=%b segs=%h fs=%b",
                 $time, bus.ssd_ctl, bus.segs, bus.frame_start, e.ctl, e.segs, e.fs);
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set_bcd(input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0);
    bus.bcd3 = d3;
    bus.bcd2 = d2;
    bus.bcd1 = d1;
    bus.bcd0 = d0;
  endtask

  initial begin
    rst         = 1'b0;
    set_bcd(4'd9, 4'd9, 4'd9, 4'd9);
    bus.dp_in   = 4'b0000;
    bus.disp_en = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(20);

    set_bcd(4'd4, 4'd3, 4'd2, 4'd1);
    bus.dp_in = 4'b0010;
    cyc(40);
    // Change mid-frame; must not appear until the next latch.
    set_bcd(4'd4, 4'd3, 4'd2, 4'd5);
    cyc(32);
    bus.bcd1 = 4'hC;
    cyc(34);
    bus.disp_en = 1'b0;
    cyc(6);
    bus.disp_en = 1'b1;
    cyc(20);

    bus.dp_in = 4'b0000;
    set_bcd(4'd0, 4'd0, 4'd0, 4'd7);
    cyc(36);
    set_bcd(4'd0, 4'd1, 4'd0, 4'd7);
    cyc(36);
    bus.dp_in = 4'b1111;
    set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
    cyc(36);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0)
        set_bcd(4'($urandom_range(15)), 4'($urandom_range(15)),
                4'($urandom_range(15)), 4'($urandom_range(15)));
      if ($urandom_range(3) == 0) begin
        bus.bcd3 = 4'd0;
        if ($urandom_range(1) == 0) bus.bcd2 = 4'd0;
      end
      if ($urandom_range(7) == 0) bus.dp_in = 4'($urandom_range(15));
      bus.disp_en = ($urandom_range(9) != 0);
      rst = !(i >= 300 && i < 302);
      cyc(1);
    end
    rst = 1'b1;
    bus.disp_en = 1'b1;
    cyc(3);

    checks++;
    if (q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required at most 1", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
